// File: rtl/router_port_drain.sv
// router_port_drain: pulls one packet at a time from a router output port and re-emits it as a ready/valid stream.
// Checks parity and address per packet, counts completed packets, and reports truncation and pre-read flushes.
module router_port_drain #(
    parameter int PORT_ID  = 0,
    parameter int CNT_W    = 16,
    parameter int TRUNC_TO = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             vld_out,
    input  logic [7:0]       data_in,
    output logic             read_enb,
    input  logic [4:0]       start_delay,
    output logic [7:0]       out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_sop,
    output logic             out_eop,
    output logic             pkt_done,
    output logic             parity_err,
    output logic             addr_err,
    output logic             trunc_err,
    output logic [5:0]       pkt_len,
    output logic [CNT_W-1:0] pkt_count,
    output logic             drop_seen
);
    localparam int TW = $clog2(TRUNC_TO + 1);

    typedef enum logic [2:0] {IDLE, WAIT, HDR, BODY, TRUNC, DONE} state_t;

    state_t      state;
    logic [4:0]  dcnt;
    logic [6:0]  rem;
    logic [7:0]  acc;
    logic [1:0]  addr;
    logic [TW-1:0] tcnt;
    logic        hdr_issued, inflight, inflight_last, par_bad;
    logic [9:0]  mem [2];
    logic        wr, rd;
    logic [1:0]  occ;
    logic        owed, push, pop;

    // Reads still owed to the current packet; the room check keeps the 2-entry skid from overflowing.
    assign owed      = (state == HDR && !hdr_issued) || (state == BODY && rem != 7'd0);
    assign read_enb  = owed && vld_out && ((occ + {1'b0, inflight}) < 2'd2);
    assign push      = inflight;
    assign out_valid = occ != 2'd0;
    assign pop       = out_valid && out_ready;
    assign {out_eop, out_sop, out_data} = mem[rd];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr     <= 1'b0;
            rd     <= 1'b0;
            occ    <= '0;
        end else begin
            if (push) begin
                mem[wr] <= {inflight_last, state == HDR, data_in};
                wr      <= ~wr;
            end
            if (pop)
                rd <= ~rd;
            occ <= occ + {1'b0, push} - {1'b0, pop};
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state         <= IDLE;
            dcnt          <= '0;
            rem           <= '0;
            acc           <= '0;
            addr          <= '0;
            tcnt          <= '0;
            hdr_issued    <= 1'b0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            par_bad       <= 1'b0;
            pkt_done      <= 1'b0;
            parity_err    <= 1'b0;
            addr_err      <= 1'b0;
            trunc_err     <= 1'b0;
            pkt_len       <= '0;
            pkt_count     <= '0;
            drop_seen     <= 1'b0;
        end else begin
            inflight      <= read_enb;
            inflight_last <= read_enb && state == BODY && rem == 7'd1;
            pkt_done      <= 1'b0;
            drop_seen     <= 1'b0;
            unique case (state)
                IDLE: begin
                    hdr_issued <= 1'b0;
                    tcnt       <= '0;
                    if (vld_out) begin
                        state <= WAIT;
                        dcnt  <= start_delay;
                    end
                end
                WAIT: begin
                    if (!vld_out) begin
                        drop_seen <= 1'b1;
                        state     <= IDLE;
                    end else if (dcnt == 5'd0)
                        state <= HDR;
                    else
                        dcnt <= dcnt - 5'd1;
                end
                HDR: begin
                    if (read_enb)
                        hdr_issued <= 1'b1;
                    if (inflight) begin
                        pkt_len <= data_in[7:2];
                        addr    <= data_in[1:0];
                        acc     <= data_in;
                        rem     <= {1'b0, data_in[7:2]} + 7'd1;
                        state   <= BODY;
                    end
                end
                BODY: begin
                    if (read_enb)
                        rem <= rem - 7'd1;
                    if (inflight && inflight_last)
                        par_bad <= data_in != acc;
                    else if (inflight)
                        acc <= acc ^ data_in;
                    if (pop && out_eop) begin
                        state      <= DONE;
                        pkt_done   <= 1'b1;
                        parity_err <= par_bad;
                        addr_err   <= addr != 2'(PORT_ID);
                        trunc_err  <= 1'b0;
                        pkt_count  <= pkt_count + CNT_W'(1);
                    end
                end
                TRUNC: begin
                    if (occ == 2'd0 && !inflight) begin
                        state      <= DONE;
                        pkt_done   <= 1'b1;
                        parity_err <= 1'b0;
                        addr_err   <= hdr_issued && addr != 2'(PORT_ID);
                        trunc_err  <= 1'b1;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
            // Starvation watchdog: only runs while the packet still owes reads.
            if (owed && !vld_out) begin
                if (tcnt == TW'(TRUNC_TO - 1))
                    state <= TRUNC;
                else
                    tcnt <= tcnt + TW'(1);
            end else if (vld_out)
                tcnt <= '0;
        end
    end
endmodule

// File: tb/tb_router_port_drain.sv
// tb_router_port_drain: router FIFO model with soft-reset timeout feeding the drain; stream and per-packet
// results are checked against expectations derived from the packet bytes.
module tb_router_port_drain;
    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        vld_out = 1'b0;
    logic [7:0]  data_in = 8'h00;
    logic        read_enb;
    logic [4:0]  start_delay = 5'd0;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        out_sop, out_eop, pkt_done, parity_err, addr_err, trunc_err, drop_seen;
    logic [5:0]  pkt_len;
    logic [15:0] pkt_count;

    router_port_drain #(.PORT_ID(1), .CNT_W(16), .TRUNC_TO(8)) dut (
        .clk(clk), .resetn(resetn), .vld_out(vld_out), .data_in(data_in), .read_enb(read_enb),
        .start_delay(start_delay), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_sop(out_sop), .out_eop(out_eop), .pkt_done(pkt_done), .parity_err(parity_err),
        .addr_err(addr_err), .trunc_err(trunc_err), .pkt_len(pkt_len), .pkt_count(pkt_count),
        .drop_seen(drop_seen)
    );

    always #5 clk = ~clk;

    logic [7:0]  fifo[$];
    logic [9:0]  exp_q[$];
    logic [7:0]  b[$];
    int          n_chk = 0, n_bad = 0;
    int          outstanding = 0, rd_total = 0, noread = 0, done_n = 0, drop_n = 0;
    int          cnt_model = 0, mode = 0, pat_i = 0;
    bit          prev_stall = 0;
    logic [10:0] prev_word;
    logic [9:0]  snap_word;
    logic [15:0] snap_cnt;
    logic [5:0]  snap_len;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        bit re, pp;
        @(negedge clk);
        if (read_enb) begin
            check("read_room", outstanding < 2, 1);
            check("read_vld", vld_out, 1);
        end
        if (prev_stall)
            check("hold", {out_valid, out_sop, out_eop, out_data}, prev_word);
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0)
                check("stream_extra", exp_q.size(), 1);
            else
                check("stream", {out_sop, out_eop, out_data}, exp_q.pop_front());
        end
        if (pkt_done) begin
            done_n++;
            snap_word = {6'd0, parity_err, addr_err, trunc_err, 1'b0};
            snap_cnt  = pkt_count;
            snap_len  = pkt_len;
        end
        if (drop_seen)
            drop_n++;
        re = read_enb;
        pp = out_valid && out_ready;
        prev_stall = out_valid && !out_ready;
        prev_word  = {out_valid, out_sop, out_eop, out_data};
        @(posedge clk);
        #1;
        if (pp) outstanding--;
        if (re && fifo.size() != 0) begin
            outstanding++;
            rd_total++;
            data_in = fifo.pop_front();
            noread = 0;
        end else if (fifo.size() != 0)
            noread++;
        else
            noread = 0;
        if (noread >= 30) begin
            fifo.delete();
            noread = 0;
        end
        vld_out = fifo.size() != 0;
        pat_i++;
        out_ready = mode == 0 ? 1'b1 : mode == 1 ? 1'($urandom_range(0, 1)) :
                    (pat_i % 4 == 0 || pat_i % 4 == 3);
    endtask

    task automatic build(input int len, input logic [1:0] a, input bit bad);
        logic [7:0] p;
        b.delete();
        b.push_back({len[5:0], a});
        p = b[0];
        for (int i = 0; i < len; i++) begin
            b.push_back(8'($urandom));
            p ^= b[$];
        end
        b.push_back(bad ? p ^ (8'h01 << $urandom_range(0, 7)) : p);
    endtask

    // cut < 0: the whole packet is offered; otherwise only header plus cut payload bytes reach the FIFO.
    task automatic run(input int cut, input int dly, input int md);
        int n;
        logic [7:0] x;
        bit par_ok;
        n = cut < 0 ? b.size() : cut + 1;
        x = 8'h00;
        foreach (b[i]) x ^= b[i];
        par_ok = x == 8'h00;
        for (int i = 0; i < n; i++) begin
            fifo.push_back(b[i]);
            exp_q.push_back({i == 0, cut < 0 && i == n - 1, b[i]});
        end
        vld_out = 1'b1;
        start_delay = 5'(dly);
        mode = md;
        rd_total = 0;
        done_n = 0;
        for (int c = 0; c < 3000 && done_n == 0; c++) step();
        check("done_seen", done_n, 1);
        if (cut < 0) cnt_model++;
        check("flags", snap_word, {6'd0, cut < 0 && !par_ok, b[0][1:0] != 2'd1, cut >= 0, 1'b0});
        check("pkt_len", snap_len, b[0][7:2]);
        check("pkt_count", snap_cnt, cnt_model);
        repeat (3) step();
        check("reads", rd_total, n);
        check("drained", exp_q.size(), 0);
        check("done_once", done_n, 1);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("reset_outs", {read_enb, out_valid, out_data, out_sop, out_eop, pkt_done, parity_err,
                             addr_err, trunc_err, pkt_len, pkt_count, drop_seen}, 0);
        resetn = 1'b1;
        repeat (2) step();

        b = '{8'h15, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h14};
        run(-1, 0, 0);
        b = '{8'h15, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h15};
        run(-1, 0, 0);
        b = '{8'h01, 8'h01};
        run(-1, 0, 0);
        build(20, 2'd1, 0);
        run(-1, 3, 2);
        build(5, 2'd2, 0);
        run(-1, 0, 1);

        // start delay longer than the router's flush timeout
        build(4, 2'd1, 0);
        foreach (b[i]) fifo.push_back(b[i]);
        vld_out = 1'b1;
        start_delay = 5'd31;
        mode = 0;
        rd_total = 0;
        done_n = 0;
        drop_n = 0;
        repeat (80) step();
        check("drop_once", drop_n, 1);
        check("drop_noread", rd_total, 0);
        check("drop_nodone", done_n, 0);
        check("drop_fifo", fifo.size(), 0);

        build(6, 2'd1, 0);
        run(3, 0, 0);

        // reset in the middle of a packet
        build(10, 2'd1, 0);
        foreach (b[i]) begin
            fifo.push_back(b[i]);
            exp_q.push_back({i == 0, i == b.size() - 1, b[i]});
        end
        vld_out = 1'b1;
        start_delay = 5'd0;
        mode = 2;
        repeat (9) step();
        resetn = 1'b0;
        #1;
        check("rst_mid_outs", {read_enb, out_valid, out_data, out_sop, out_eop, pkt_done, parity_err,
                               addr_err, trunc_err, pkt_len, pkt_count, drop_seen}, 0);
        fifo.delete();
        exp_q.delete();
        outstanding = 0;
        prev_stall = 0;
        vld_out = 1'b0;
        cnt_model = 0;
        #2;
        resetn = 1'b1;
        repeat (2) step();
        build(3, 2'd1, 0);
        run(-1, 1, 0);

        for (int k = 0; k < 25; k++) begin
            int len;
            len = $urandom_range(0, 40);
            build(len, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
            run($urandom_range(0, 4) == 0 ? $urandom_range(0, len) : -1, $urandom_range(0, 15),
                $urandom_range(0, 2));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_bad);
        $finish;
    end
endmodule
